// File: rtl/mem_port_arbiter_if.sv
// Bundle of the fetch, LSU and memory-port signals around the shared memory arbiter.
// slave is the arbiter's view; master is the view of the units and memory around it.
interface mem_port_arbiter_if;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_gnt;
  logic        if_rvalid;
  logic [31:0] if_rdata;

  logic        ls_req;
  logic [3:0]  ls_we;
  logic [31:0] ls_addr;
  logic [31:0] ls_wdata;
  logic        ls_gnt;
  logic        ls_rvalid;
  logic [31:0] ls_rdata;

  logic        mem_req;
  logic [3:0]  mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ready;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;

  logic        protocol_err;

  modport slave (
    input  if_req, if_addr,
    input  ls_req, ls_we, ls_addr, ls_wdata,
    input  mem_ready, mem_rvalid, mem_rdata,
    output if_gnt, if_rvalid, if_rdata,
    output ls_gnt, ls_rvalid, ls_rdata,
    output mem_req, mem_we, mem_addr, mem_wdata,
    output protocol_err
  );

  modport master (
    output if_req, if_addr,
    output ls_req, ls_we, ls_addr, ls_wdata,
    output mem_ready, mem_rvalid, mem_rdata,
    input  if_gnt, if_rvalid, if_rdata,
    input  ls_gnt, ls_rvalid, ls_rdata,
    input  mem_req, mem_we, mem_addr, mem_wdata,
    input  protocol_err
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Arbitrates fetch and LSU onto one memory port, LSU first, with a starvation
// counter that forces a fetch win; tracks the single outstanding read and routes its response.
module mem_port_arbiter #(
  parameter int STARVE_MAX = 4
) (
  input logic                clk,
  input logic                rst,
  mem_port_arbiter_if.slave  bus
);

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  state_t     state;
  logic       owner_ls;
  logic [3:0] starve_cnt;
  logic       protocol_err_q;

  logic issue_window;
  logic fetch_wins;
  logic grant;
  logic ls_is_write;
  logic read_accept;
  logic resp_valid;

  // A returning response frees the port, so a new access may issue in the same cycle.
  assign issue_window = (state == S_IDLE) || bus.mem_rvalid;
  assign fetch_wins   = (starve_cnt == STARVE_LIM) || !bus.ls_req;

  assign bus.mem_req   = !rst && issue_window && (fetch_wins ? bus.if_req : bus.ls_req);
  assign bus.mem_addr  = fetch_wins ? bus.if_addr : bus.ls_addr;
  assign bus.mem_we    = fetch_wins ? 4'b0000 : bus.ls_we;
  assign bus.mem_wdata = fetch_wins ? 32'h0 : bus.ls_wdata;

  assign grant      = bus.mem_req && bus.mem_ready;
  assign bus.if_gnt = grant && fetch_wins;
  assign bus.ls_gnt = grant && !fetch_wins;

  assign ls_is_write = |bus.ls_we;
  assign read_accept = bus.if_gnt || (bus.ls_gnt && !ls_is_write);

  // Responses arriving with nothing outstanding are dropped rather than routed.
  assign resp_valid    = bus.mem_rvalid && (state == S_WAIT);
  assign bus.if_rvalid = resp_valid && !owner_ls;
  assign bus.ls_rvalid = resp_valid && owner_ls;
  assign bus.if_rdata  = bus.mem_rdata;
  assign bus.ls_rdata  = bus.mem_rdata;

  assign bus.protocol_err = protocol_err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= S_IDLE;
      owner_ls       <= 1'b0;
      starve_cnt     <= 4'd0;
      protocol_err_q <= 1'b0;
    end else begin
      if (bus.mem_rvalid && (state == S_IDLE))
        protocol_err_q <= 1'b1;

      if (read_accept) begin
        state    <= S_WAIT;
        owner_ls <= bus.ls_gnt;
      end else if ((state == S_WAIT) && bus.mem_rvalid) begin
        state <= S_IDLE;
      end

      // Only losses while fetch is actually waiting count towards starvation.
      if (bus.if_gnt)
        starve_cnt <= 4'd0;
      else if (bus.ls_gnt && bus.if_req && (starve_cnt != STARVE_LIM))
        starve_cnt <= starve_cnt + 4'd1;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a single-cycle memory model behind the port.
module tb_mem_port_arbiter;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_port_arbiter_if bus();

  logic        model_en;
  logic        man_rvalid;
  logic [31:0] man_rdata;
  logic        model_rvalid;
  logic [31:0] model_rdata;
  logic [31:0] mem [128];

  int n_checks = 0;
  int n_fail   = 0;

  assign bus.mem_rvalid = model_en ? model_rvalid : man_rvalid;
  assign bus.mem_rdata  = model_en ? model_rdata  : man_rdata;

  mem_port_arbiter #(.STARVE_MAX(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Single-cycle memory: answers an accepted read on the following cycle.
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 128; i++) mem[i] <= 32'h0;
      mem[0]       <= 32'h00000013;
      mem[1]       <= 32'h00100093;
      mem[2]       <= 32'h00200113;
      mem[3]       <= 32'h00308193;
      mem[16]      <= 32'hCAFE0010;
      mem[64]      <= 32'h11223344;
      model_rvalid <= 1'b0;
      model_rdata  <= 32'h0;
    end else begin
      model_rvalid <= bus.mem_req && bus.mem_ready && (bus.mem_we == 4'b0000);
      model_rdata  <= mem[bus.mem_addr[8:2]];
      if (bus.mem_req && bus.mem_ready) begin
        for (int b = 0; b < 4; b++)
          if (bus.mem_we[b]) mem[bus.mem_addr[8:2]][8*b +: 8] <= bus.mem_wdata[8*b +: 8];
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("[TB] FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  initial begin
    rst            = 1'b1;
    model_en       = 1'b1;
    man_rvalid     = 1'b0;
    man_rdata      = 32'h0;
    bus.if_req     = 1'b1;
    bus.if_addr    = 32'h0;
    bus.ls_req     = 1'b1;
    bus.ls_we      = 4'b0000;
    bus.ls_addr    = 32'h40;
    bus.ls_wdata   = 32'h0;
    bus.mem_ready  = 1'b1;
    tick();

    // Reset held for three cycles with both units requesting.
    for (int i = 0; i < 3; i++) begin
      #1;
      check("rst_mem_req", bus.mem_req, 1'b0);
      check("rst_if_gnt",  bus.if_gnt,  1'b0);
      check("rst_ls_gnt",  bus.ls_gnt,  1'b0);
      tick();
    end
    rst = 1'b0;
    #1;
    check("post_rst_ls_gnt",    bus.ls_gnt,       1'b1);
    check("post_rst_if_gnt",    bus.if_gnt,       1'b0);
    check("post_rst_mem_addr",  bus.mem_addr,     32'h40);
    check("post_rst_if_rvalid", bus.if_rvalid,    1'b0);
    check("post_rst_ls_rvalid", bus.ls_rvalid,    1'b0);
    check("post_rst_perr",      bus.protocol_err, 1'b0);
    check("post_rst_starve",    dut.starve_cnt,   4'd0);
    tick();
    bus.if_req = 1'b0;
    bus.ls_req = 1'b0;
    #1;
    check("rst_read_ls_rvalid", bus.ls_rvalid, 1'b1);
    check("rst_read_ls_rdata",  bus.ls_rdata,  32'hCAFE0010);
    check("rst_read_if_rvalid", bus.if_rvalid, 1'b0);
    check("rst_read_mem_req",   bus.mem_req,   1'b0);
    tick();

    // Fetch-only stream; idle LSU payload must not leak onto the port.
    bus.ls_we    = 4'hF;
    bus.ls_wdata = 32'hFFFFFFFF;
    bus.if_req   = 1'b1;
    bus.if_addr  = 32'h0;
    #1;
    check("fetch0_if_gnt",    bus.if_gnt,    1'b1);
    check("fetch0_ls_gnt",    bus.ls_gnt,    1'b0);
    check("fetch0_mem_addr",  bus.mem_addr,  32'h0);
    check("fetch0_mem_we",    bus.mem_we,    4'b0000);
    check("fetch0_mem_wdata", bus.mem_wdata, 32'h0);
    tick();
    bus.if_addr = 32'h4;
    #1;
    check("fetch1_if_gnt",    bus.if_gnt,    1'b1);
    check("fetch1_if_rvalid", bus.if_rvalid, 1'b1);
    check("fetch1_if_rdata",  bus.if_rdata,  32'h00000013);
    check("fetch1_ls_rvalid", bus.ls_rvalid, 1'b0);
    tick();
    bus.if_addr = 32'h8;
    #1;
    check("fetch2_if_gnt",    bus.if_gnt,    1'b1);
    check("fetch2_if_rvalid", bus.if_rvalid, 1'b1);
    check("fetch2_if_rdata",  bus.if_rdata,  32'h00100093);
    tick();
    bus.if_req = 1'b0;
    #1;
    check("fetch3_if_gnt",    bus.if_gnt,     1'b0);
    check("fetch3_if_rvalid", bus.if_rvalid,  1'b1);
    check("fetch3_if_rdata",  bus.if_rdata,   32'h00200113);
    check("fetch3_starve",    dut.starve_cnt, 4'd0);
    tick();

    // LSU partial write followed by a read of the same word.
    bus.ls_req   = 1'b1;
    bus.ls_we    = 4'b0011;
    bus.ls_addr  = 32'h100;
    bus.ls_wdata = 32'hDEADBEEF;
    #1;
    check("lsw_ls_gnt",    bus.ls_gnt,    1'b1);
    check("lsw_mem_we",    bus.mem_we,    4'b0011);
    check("lsw_mem_wdata", bus.mem_wdata, 32'hDEADBEEF);
    check("lsw_mem_addr",  bus.mem_addr,  32'h100);
    tick();
    bus.ls_we = 4'b0000;
    #1;
    check("lsr_ls_gnt",         bus.ls_gnt,    1'b1);
    check("lsr_mem_we",         bus.mem_we,    4'b0000);
    check("lsw_no_ls_rvalid",   bus.ls_rvalid, 1'b0);
    tick();
    bus.ls_req = 1'b0;
    #1;
    check("lsr_ls_rvalid", bus.ls_rvalid, 1'b1);
    check("lsr_ls_rdata",  bus.ls_rdata,  32'h1122BEEF);
    check("lsr_if_rvalid", bus.if_rvalid, 1'b0);
    tick();

    // Both requesting: four LSU wins, then fetch, repeating.
    bus.if_req   = 1'b1;
    bus.if_addr  = 32'hC;
    bus.ls_req   = 1'b1;
    bus.ls_we    = 4'hF;
    bus.ls_addr  = 32'h200;
    bus.ls_wdata = 32'h55AA55AA;
    for (int k = 0; k < 10; k++) begin
      #1;
      check($sformatf("starve%0d_if_gnt", k), bus.if_gnt,     (k % 5) == 4);
      check($sformatf("starve%0d_ls_gnt", k), bus.ls_gnt,     (k % 5) != 4);
      check($sformatf("starve%0d_cnt", k),    dut.starve_cnt, 32'(k % 5));
      tick();
    end

    // One more LSU win, then a five-cycle memory stall.
    #1;
    check("stall0_ls_gnt",    bus.ls_gnt,    1'b1);
    check("stall0_if_rvalid", bus.if_rvalid, 1'b1);
    check("stall0_if_rdata",  bus.if_rdata,  32'h00308193);
    tick();
    bus.mem_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      #1;
      check($sformatf("stall%0d_if_gnt", k + 1),  bus.if_gnt,     1'b0);
      check($sformatf("stall%0d_ls_gnt", k + 1),  bus.ls_gnt,     1'b0);
      check($sformatf("stall%0d_mem_req", k + 1), bus.mem_req,    1'b1);
      check($sformatf("stall%0d_cnt", k + 1),     dut.starve_cnt, 4'd1);
      tick();
    end
    bus.mem_ready = 1'b1;
    #1;
    check("unstall_ls_gnt", bus.ls_gnt,     1'b1);
    check("unstall_if_gnt", bus.if_gnt,     1'b0);
    check("unstall_cnt",    dut.starve_cnt, 4'd1);
    tick();
    bus.if_req = 1'b0;
    bus.ls_req = 1'b0;
    #1;
    check("unstall_cnt_after", dut.starve_cnt, 4'd2);
    tick();

    // Spurious response while idle: dropped, and the error sticks until reset.
    model_en   = 1'b0;
    man_rvalid = 1'b1;
    man_rdata  = 32'h00000BAD;
    #1;
    check("spur_if_rvalid", bus.if_rvalid,    1'b0);
    check("spur_ls_rvalid", bus.ls_rvalid,    1'b0);
    check("spur_perr_pre",  bus.protocol_err, 1'b0);
    tick();
    man_rvalid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      check($sformatf("spur_perr_sticky%0d", k), bus.protocol_err, 1'b1);
      tick();
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    check("perr_cleared", bus.protocol_err, 1'b0);

    // Reset with a fetch read outstanding: its late response counts as spurious.
    bus.if_req  = 1'b1;
    bus.if_addr = 32'h10;
    #1;
    check("midrd_if_gnt", bus.if_gnt, 1'b1);
    tick();
    bus.if_req = 1'b0;
    rst        = 1'b1;
    tick();
    rst        = 1'b0;
    man_rvalid = 1'b1;
    #1;
    check("midrd_if_rvalid", bus.if_rvalid,    1'b0);
    check("midrd_ls_rvalid", bus.ls_rvalid,    1'b0);
    check("midrd_perr_pre",  bus.protocol_err, 1'b0);
    tick();
    man_rvalid = 1'b0;
    #1;
    check("midrd_perr", bus.protocol_err, 1'b1);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Two-requester arbiter sharing one single-ported unified instruction/data memory between the fetch unit and the load/store unit of the RISC-V core. It sits between those two units and the memory port. It:

- serialises their accesses with a request/grant handshake;
- tracks the single outstanding read and routes its response back to the owner;
- prioritises the LSU while guaranteeing fetch forward progress with a starvation counter.

## Interface

Parameters:
- STARVE_MAX, 4: consecutive lost arbitrations after which fetch wins the next arbitration (1..15).

Ports:
- clk  in  1  core clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- if_req  in  1  fetch read request; held with if_addr until if_gnt.
- if_addr  in  32  fetch byte address.
- if_gnt  out  1  fetch request accepted this cycle.
- if_rvalid  out  1  fetch read data valid.
- if_rdata  out  32  fetch read data.
- ls_req  in  1  LSU request; held with ls_addr/ls_we/ls_wdata until ls_gnt.
- ls_we  in  4  byte write enables; 4'b0000 means read.
- ls_addr  in  32  LSU byte address.
- ls_wdata  in  32  LSU write data.
- ls_gnt  out  1  LSU request accepted this cycle.
- ls_rvalid  out  1  LSU read data valid.
- ls_rdata  out  32  LSU read data.
- mem_req  out  1  memory request.
- mem_we  out  4  memory byte write enables.
- mem_addr  out  32  memory address.
- mem_wdata  out  32  memory write data.
- mem_ready  in  1  memory accepts mem_req this cycle.
- mem_rvalid  in  1  memory read response valid.
- mem_rdata  in  32  memory read data.
- protocol_err  out  1  sticky: mem_rvalid seen with no outstanding read.

## Operation

State machine:
- States: IDLE (no read outstanding) and WAIT (one read outstanding). A registered owner bit (IF/LS) records who issued the read.
- Issue window: state==IDLE, or state==WAIT with mem_rvalid==1. The response and a new issue may share one cycle.
- Arbitration, issue window only:
  - Fetch wins if starve_cnt==STARVE_MAX, or if ls_req==0.
  - Otherwise the LSU wins.
- Memory outputs (combinational): mem_req = winner's req, only in the issue window. mem_addr, mem_we and mem_wdata are muxed from the winner; mem_we and mem_wdata are 0 for fetch.
- Grant: gnt = mem_req & mem_ready, to the winner only. At most one of if_gnt/ls_gnt is high in any cycle.
- Accepted read (fetch, or LSU with ls_we==0): next state WAIT, owner <= winner.
- Accepted write (ls_we!=0): completes at grant; no response. Next state is IDLE, unless a read was accepted in the same cycle.
- WAIT with mem_rvalid and no new read accepted: next state IDLE.
- Response routing:
  - if_rdata = ls_rdata = mem_rdata (passthrough).
  - if_rvalid = mem_rvalid & state==WAIT & owner==IF.
  - ls_rvalid = mem_rvalid & state==WAIT & owner==LS.
- starve_cnt (4-bit):
  - clears to 0 on if_gnt;
  - increments, saturating at STARVE_MAX, on any ls_gnt cycle where if_req==1;
  - otherwise holds.
- protocol_err is set when mem_rvalid==1 with state==IDLE. That response is dropped: neither rvalid is raised.

## Timing

- Reset (rst high at an edge):
  - state IDLE, owner IF, starve_cnt 0, protocol_err 0.
  - While rst==1, mem_req, if_gnt and ls_gnt are forced 0.
  - if_rvalid and ls_rvalid are 0 in the cycle after the reset edge.
- Reset mid-read: the outstanding read is abandoned. A later mem_rvalid is treated as spurious and sets protocol_err.
- Latency: grant is same-cycle with mem_ready (0 added cycles). Read data latency equals the memory latency; the arbiter adds no registers on the data path.
- Back-to-back reads with single-cycle memory: one grant per cycle, full throughput.
- Requester held off (no gnt): it must keep req and payload stable. Dropping req before gnt is legal and cancels the request.
- mem_ready==0: no gnt to anyone, starve_cnt unchanged, arbitration recomputed next cycle.

## Test plan

- Reset: hold rst 3 cycles with if_req=ls_req=1 → mem_req, if_gnt, ls_gnt =0 throughout; after release, ls_gnt=1 in the first cycle (mem_ready=1).
- Fetch only, 1-cycle memory, if_addr 0x0,0x4,0x8 → if_gnt on 3 consecutive cycles; if_rvalid on the next 3 cycles with data 0x00000013, 0x00100093, 0x00200113 in order.
- LSU write then read, ls_we=4'b0011, addr 0x100, wdata 0xDEADBEEF, then read addr 0x100 → mem_we=0011 on the write grant; no ls_rvalid for the write; ls_rvalid with mem_rdata on the read.
- Starvation, STARVE_MAX=4, both requesting continuously → grants LS,LS,LS,LS,IF, then the pattern repeats; starve_cnt returns to 0 after each IF grant.
- mem_ready stall, both requesting, mem_ready=0 for 5 cycles → no grants, starve_cnt frozen; first grant follows mem_ready=1.
- Spurious response: mem_rvalid=1 while IDLE → protocol_err=1 from the next cycle, if_rvalid=ls_rvalid=0; protocol_err stays 1 until rst.
